// File: rtl/acc_pkg.sv
// Shared constants and types for the accumulator result arbiter.
// Entries are stored as {last, addr, data} in every column FIFO.
package acc_pkg;

    localparam int N_COL  = 16;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic              last;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } acc_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } acc_state_e;

endpackage

// File: rtl/acc_col_fifo.sv
// Small synchronous FIFO for one accumulator column.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module acc_col_fifo #(
    parameter int W     = 19,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/acc_result_arbiter.sv
// Serialises per-column accumulator results onto one write port through
// per-column FIFOs, a round-robin arbiter and a layer-tracking FSM.
module acc_result_arbiter #(
    parameter int N_COL  = acc_pkg::N_COL,
    parameter int DATA_W = acc_pkg::DATA_W,
    parameter int ADDR_W = acc_pkg::ADDR_W,
    parameter int DEPTH  = acc_pkg::DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start_i,
    input  logic [N_COL-1:0]          conv_valid_i,
    input  logic [N_COL-1:0]          conv_last_i,
    input  logic [N_COL*DATA_W-1:0]   conv_result_i,
    input  logic [N_COL*ADDR_W-1:0]   addr_i,
    output logic [N_COL-1:0]          col_ready_o,
    output logic                      wr_valid_o,
    input  logic                      wr_ready_i,
    output logic [DATA_W-1:0]         wr_data_o,
    output logic [ADDR_W-1:0]         wr_addr_o,
    output logic [$clog2(N_COL)-1:0]  wr_col_o,
    output logic                      wr_last_o,
    output logic                      busy_o,
    output logic                      layer_done_o,
    output logic [N_COL-1:0]          ovf_o
);

    import acc_pkg::*;

    localparam int COL_W = $clog2(N_COL);
    localparam int CNT_W = $clog2(DEPTH + 1);

    acc_entry_t       fifo_din   [N_COL];
    acc_entry_t       fifo_dout  [N_COL];
    logic [CNT_W-1:0] fifo_count [N_COL];
    logic [N_COL-1:0] fifo_full;
    logic [N_COL-1:0] fifo_empty;
    logic [N_COL-1:0] pop;
    logic [N_COL-1:0] overflow;
    logic [N_COL-1:0] last_hit;

    logic             load;
    logic             found;
    logic [COL_W-1:0] grant;
    logic             start_ok;

    acc_state_e       state_q, state_d;
    logic [COL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             wr_valid_q, wr_valid_d;
    acc_entry_t       wr_entry_q, wr_entry_d;
    logic [COL_W-1:0] wr_col_q, wr_col_d;
    logic [N_COL-1:0] last_seen_q, last_seen_d;
    logic [N_COL-1:0] ovf_q, ovf_d;

    for (genvar c = 0; c < N_COL; c++) begin : g_col
        assign fifo_din[c] = '{last: conv_last_i[c],
                               addr: addr_i[c*ADDR_W +: ADDR_W],
                               data: conv_result_i[c*DATA_W +: DATA_W]};
        assign col_ready_o[c] = (fifo_count[c] != CNT_W'(DEPTH));

        acc_col_fifo #(
            .W     ($bits(acc_entry_t)),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (conv_valid_i[c]),
            .pop_i   (pop[c]),
            .din_i   (fifo_din[c]),
            .dout_o  (fifo_dout[c]),
            .full_o  (fifo_full[c]),
            .empty_o (fifo_empty[c]),
            .count_o (fifo_count[c])
        );
    end

    // The output register may load whenever it is empty or its beat is leaving.
    assign load     = !wr_valid_q || wr_ready_i;
    assign overflow = conv_valid_i & fifo_full & ~pop;
    assign last_hit = conv_valid_i & conv_last_i;
    assign start_ok = (state_q == IDLE) && cfg_start_i;

    always_comb begin
        found = 1'b0;
        grant = rr_ptr_q;
        for (int i = 0; i < N_COL; i++) begin
            if (!found && !fifo_empty[(int'(rr_ptr_q) + i) % N_COL]) begin
                found = 1'b1;
                grant = COL_W'((int'(rr_ptr_q) + i) % N_COL);
            end
        end
        pop        = '0;
        pop[grant] = load && found;
    end

    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_entry_d = wr_entry_q;
        wr_col_d   = wr_col_q;
        rr_ptr_d   = rr_ptr_q;
        if (load) begin
            wr_valid_d = found;
            if (found) begin
                wr_entry_d = fifo_dout[grant];
                wr_col_d   = grant;
                rr_ptr_d   = COL_W'((int'(grant) + 1) % N_COL);
            end
        end
    end

    // A new layer wipes history; overflow seen in the start cycle still counts.
    always_comb begin
        last_seen_d = last_seen_q;
        if (start_ok) begin
            last_seen_d = '0;
        end else if (state_q == RUN) begin
            last_seen_d = last_seen_q | last_hit;
        end
        ovf_d = (start_ok ? '0 : ovf_q) | overflow;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_start_i) state_d = RUN;
            RUN:     if (&(last_seen_q | last_hit)) state_d = DRAIN;
            DRAIN:   if (&fifo_empty && load) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != IDLE);
        layer_done_o = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            wr_valid_q  <= 1'b0;
            wr_entry_q  <= '0;
            wr_col_q    <= '0;
            last_seen_q <= '0;
            ovf_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wr_valid_q  <= wr_valid_d;
            wr_entry_q  <= wr_entry_d;
            wr_col_q    <= wr_col_d;
            last_seen_q <= last_seen_d;
            ovf_q       <= ovf_d;
        end
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_data_o  = wr_entry_q.data;
    assign wr_addr_o  = wr_entry_q.addr;
    assign wr_last_o  = wr_entry_q.last;
    assign wr_col_o   = wr_col_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_acc_result_arbiter.sv
// Directed and random stimulus for acc_result_arbiter, checked every cycle
// against a queue-based reference model of the column FIFOs and write port.
module tb_acc_result_arbiter;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int D  = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
    localparam int S_DONE  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            cfg_start;
    logic            wr_ready;
    logic [N-1:0]    cv;
    logic [N-1:0]    cl;
    logic [N*DW-1:0] cr;
    logic [N*AW-1:0] ca;

    logic [N-1:0]    col_ready_o;
    logic            wr_valid_o;
    logic [DW-1:0]   wr_data_o;
    logic [AW-1:0]   wr_addr_o;
    logic [3:0]      wr_col_o;
    logic            wr_last_o;
    logic            busy_o;
    logic            layer_done_o;
    logic [N-1:0]    ovf_o;

    acc_result_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start_i   (cfg_start),
        .conv_valid_i  (cv),
        .conv_last_i   (cl),
        .conv_result_i (cr),
        .addr_i        (ca),
        .col_ready_o   (col_ready_o),
        .wr_valid_o    (wr_valid_o),
        .wr_ready_i    (wr_ready),
        .wr_data_o     (wr_data_o),
        .wr_addr_o     (wr_addr_o),
        .wr_col_o      (wr_col_o),
        .wr_last_o     (wr_last_o),
        .busy_o        (busy_o),
        .layer_done_o  (layer_done_o),
        .ovf_o         (ovf_o)
    );

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int hs_col[$];
    int exp_order[6] = '{0, 5, 15, 0, 5, 15};

    // Reference model: one queue of {last, addr, data} per column.
    logic [AW+DW:0] q[N][$];
    bit             m_valid;
    logic [DW-1:0]  m_data;
    logic [AW-1:0]  m_addr;
    int             m_col;
    bit             m_last;
    int             m_rr;
    int             m_state;
    logic [N-1:0]   m_seen;
    logic [N-1:0]   m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit found;
        bit load;
        bit empty_all;
        int g;
        logic [AW+DW:0] e;
        if (rst) begin
            for (int c = 0; c < N; c++) q[c].delete();
            m_valid = 0; m_data = '0; m_addr = '0; m_col = 0; m_last = 0;
            m_rr = 0; m_state = S_IDLE; m_seen = '0; m_ovf = '0;
            return;
        end
        load  = !m_valid || wr_ready;
        found = 0;
        g     = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && q[(m_rr + i) % N].size() != 0) begin
                found = 1;
                g = (m_rr + i) % N;
            end
        end
        empty_all = 1;
        for (int c = 0; c < N; c++) if (q[c].size() != 0) empty_all = 0;
        case (m_state)
            S_IDLE:  if (cfg_start) begin m_seen = '0; m_ovf = '0; m_state = S_RUN; end
            S_RUN:   begin m_seen = m_seen | (cv & cl); if (&m_seen) m_state = S_DRAIN; end
            S_DRAIN: if (empty_all && load) m_state = S_DONE;
            default: m_state = S_IDLE;
        endcase
        if (load) begin
            m_valid = found;
            if (found) begin
                e = q[g].pop_front();
                {m_last, m_addr, m_data} = e;
                m_col = g;
                m_rr  = (g + 1) % N;
            end
        end
        for (int c = 0; c < N; c++) begin
            if (cv[c]) begin
                if (q[c].size() < D) q[c].push_back({cl[c], ca[c*AW +: AW], cr[c*DW +: DW]});
                else m_ovf[c] = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_rdy;
        for (int c = 0; c < N; c++) exp_rdy[c] = (q[c].size() < D);
        chk("wr_valid", wr_valid_o, m_valid);
        if (m_valid) begin
            chk("wr_data", wr_data_o, m_data);
            chk("wr_addr", wr_addr_o, m_addr);
            chk("wr_col", wr_col_o, m_col);
            chk("wr_last", wr_last_o, m_last);
        end
        chk("busy", busy_o, m_state != S_IDLE);
        chk("layer_done", layer_done_o, m_state == S_DONE);
        chk("ovf", ovf_o, m_ovf);
        chk("col_ready", col_ready_o, exp_rdy);
    endtask

    task automatic step();
        if (wr_valid_o === 1'b1 && wr_ready) hs_col.push_back(int'(wr_col_o));
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
        if (layer_done_o === 1'b1) done_cnt++;
    endtask

    task automatic push(input int c, input logic [DW-1:0] d, input logic [AW-1:0] a, input bit l);
        cv[c] = 1'b1;
        cl[c] = l;
        cr[c*DW +: DW] = d;
        ca[c*AW +: AW] = a;
    endtask

    task automatic clr();
        cv = '0;
        cl = '0;
    endtask

    initial begin
        int n2;
        rst = 1'b1; cfg_start = 1'b0; wr_ready = 1'b1;
        cv = '0; cl = '0; cr = '0; ca = '0;

        // Reset values
        step(); step();
        chk("rst_valid", wr_valid_o, 0);
        chk("rst_data", wr_data_o, 0);
        chk("rst_col_ready", col_ready_o, 16'hFFFF);
        chk("rst_busy", busy_o, 0);
        chk("rst_ovf", ovf_o, 0);
        rst = 1'b0;

        // Single column: valid appears after the second edge
        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        push(3, 8'h5A, 10'd7, 0); step(); clr();
        chk("t1_not_yet", wr_valid_o, 0);
        step();
        chk("t1_valid", wr_valid_o, 1);
        chk("t1_data", wr_data_o, 8'h5A);
        chk("t1_addr", wr_addr_o, 10'd7);
        chk("t1_col", wr_col_o, 3);
        chk("t1_no_done", layer_done_o, 0);
        step();

        // Fairness from a fresh round-robin pointer
        rst = 1'b1; step(); rst = 1'b0;
        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        hs_col.delete();
        for (int k = 0; k < 2; k++) begin
            push(0, 8'(k), 10'd0, 0); push(5, 8'(k), 10'd5, 0); push(15, 8'(k), 10'd15, 0);
            step(); clr();
        end
        repeat (8) step();
        chk("fair_count", hs_col.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < hs_col.size()) chk($sformatf("fair_order_%0d", i), hs_col[i], exp_order[i]);
        end

        // Back-pressure on column 2: six pushes, one dropped
        wr_ready = 1'b0; hs_col.delete();
        for (int k = 0; k < 6; k++) begin
            push(2, 8'(8'h10 + k), 10'(100 + k), 0); step(); clr();
        end
        repeat (4) step();
        chk("bp_ovf", ovf_o[2], 1);
        chk("bp_ready", col_ready_o[2], 0);
        chk("bp_hold_data", wr_data_o, 8'h10);
        chk("bp_hold_valid", wr_valid_o, 1);

        // Start outside IDLE must not clear overflow
        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        chk("ign_ovf", ovf_o[2], 1);
        chk("ign_busy", busy_o, 1);

        wr_ready = 1'b1;
        repeat (8) step();
        n2 = 0;
        foreach (hs_col[i]) if (hs_col[i] == 2) n2++;
        chk("bp_drain_col2", n2, 5);
        chk("bp_drain_total", hs_col.size(), 5);

        // Full FIFO: push and pop in the same cycle is not an overflow
        wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(9, 8'(8'h90 + k), 10'd9, 0); step(); clr();
        end
        chk("fp_full", col_ready_o[9], 0);
        wr_ready = 1'b1; push(9, 8'hEE, 10'd9, 0); step(); clr(); wr_ready = 1'b0;
        chk("fp_ovf", ovf_o[9], 0);
        chk("fp_still_full", col_ready_o[9], 0);
        wr_ready = 1'b1;
        repeat (8) step();

        // Layer end: lasts spread over cycles, beats still queued
        done_cnt = 0;
        for (int c = 0; c < 6; c++) push(c, 8'(c), 10'(c), 1);
        step(); clr(); step();
        for (int c = 6; c < 13; c++) push(c, 8'(c), 10'(c), 1);
        step(); clr();
        for (int c = 13; c < 16; c++) push(c, 8'(c), 10'(c), 1);
        step(); clr();
        chk("le_busy_drain", busy_o, 1);
        chk("le_no_early_done", done_cnt, 0);
        repeat (40) step();
        chk("le_done_once", done_cnt, 1);
        chk("le_busy_end", busy_o, 0);

        // Reset in RUN with data queued
        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        wr_ready = 1'b0;
        push(1, 8'h11, 10'd1, 0); push(7, 8'h77, 10'd7, 0); step(); clr();
        push(1, 8'h12, 10'd2, 0); step(); clr();
        rst = 1'b1; step(); rst = 1'b0;
        chk("mr_valid", wr_valid_o, 0);
        chk("mr_col_ready", col_ready_o, 16'hFFFF);
        chk("mr_busy", busy_o, 0);
        wr_ready = 1'b1;
        repeat (3) step();
        chk("mr_empty", wr_valid_o, 0);

        // Random traffic, then every column finishes
        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        done_cnt = 0;
        repeat (300) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 31) == 0) push(c, 8'($urandom), 10'($urandom), 0);
            end
            wr_ready = ($urandom_range(0, 3) != 0);
            step(); clr();
        end
        chk("rnd_no_done", done_cnt, 0);
        for (int c = 0; c < N; c++) push(c, 8'($urandom), 10'($urandom), 1);
        wr_ready = 1'b1;
        step(); clr();
        repeat (150) begin
            wr_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        chk("rnd_done_once", done_cnt, 1);
        chk("rnd_busy_end", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
